// File: rtl/traffic_light_monitor.sv
// Safety monitor downstream of traffic_lights: passes legal lamp patterns, latches faults.
// Optional TLMON_FAULT_CNT_EN adds an 8-bit saturating fault_count output.
module traffic_light_monitor #(
   parameter int MIN_YELLOW = 3,
   parameter int MAX_GREEN  = 50,
   parameter int CNT_W      = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] light_1,
   input  logic [2:0] light_2,
   input  logic       clr_fault,
   output logic [2:0] safe_1,
   output logic [2:0] safe_2,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic [1:0] fault_chan
`ifdef TLMON_FAULT_CNT_EN
   ,
   output logic [7:0] fault_count
`endif
);

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] L_MIN_Y = CNT_W'(MIN_YELLOW);
   localparam logic [CNT_W-1:0] L_GTO   = CNT_W'(MAX_GREEN - 1);

   typedef enum logic [1:0] {
      S_INIT,
      S_RUN,
      S_FAULT
   } state_t;

   state_t                r_state;
   logic [1:0][2:0]       r_cur;
   logic [1:0][2:0]       r_prev;
   logic [1:0][CNT_W-1:0] r_cnt;
   logic [2:0]            r_safe_1;
   logic [2:0]            r_safe_2;
   logic                  r_fault;
   logic [2:0]            r_code;
   logic [1:0]            r_chan;

   logic [1:0][2:0]       w_light;
   logic                  w_conf;
   logic [1:0]            w_inv;
   logic [1:0]            w_chg;
   logic [1:0]            w_ill;
   logic [1:0]            w_ysh;
   logic [1:0]            w_gto;
   logic                  w_seq;
   logic [2:0]            w_code;
   logic [1:0]            w_chan;
   logic                  w_hit;

   assign w_light = {light_2, light_1};

   // Input sample register; free-running so INIT sees real lights after reset.
   always_ff @(posedge clk) begin
      r_cur <= w_light;
   end

   // Per-channel checks on the registered sample against the previous one.
   always_comb begin
      w_inv = '0;
      w_chg = '0;
      w_ill = '0;
      w_ysh = '0;
      w_gto = '0;
      w_conf = (|r_cur[0][1:0]) && (|r_cur[1][1:0]);
      for (int i = 0; i < 2; i++) begin
         w_inv[i] = !$onehot(r_cur[i]);
         w_chg[i] = r_cur[i] != r_prev[i];
         w_ill[i] = w_chg[i] &&
                    !((r_prev[i] == GRN && r_cur[i] == YEL) ||
                      (r_prev[i] == YEL && r_cur[i] == RED) ||
                      (r_prev[i] == RED && r_cur[i] == GRN));
         w_ysh[i] = r_prev[i] == YEL && r_cur[i] == RED &&
                    r_cnt[i] != CNT_MAX && r_cnt[i] < L_MIN_Y;
         // The count belongs to the previous colour on a change, so
         // the watchdog only looks at a green that is continuing.
         w_gto[i] = r_cur[i] == GRN && !w_chg[i] &&
                    (r_cnt[i] == L_GTO || r_cnt[i] == CNT_MAX);
      end
   end

   // Lowest code wins; channel mask is the set that fired that code.
   always_comb begin
      w_seq  = r_state == S_RUN;
      w_code = '0;
      w_chan = '0;
      if (w_conf) begin
         w_code = 3'd1;
         w_chan = 2'b11;
      end else if (|w_inv) begin
         w_code = 3'd2;
         w_chan = w_inv;
      end else if (w_seq && |w_ill) begin
         w_code = 3'd3;
         w_chan = w_ill;
      end else if (w_seq && |w_ysh) begin
         w_code = 3'd4;
         w_chan = w_ysh;
      end else if (w_seq && |w_gto) begin
         w_code = 3'd5;
         w_chan = w_gto;
      end
      w_hit = w_code != 3'd0;
   end

   // Monitor FSM with registered lamp drive and sticky fault report.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= S_INIT;
         r_prev   <= '0;
         r_cnt    <= '0;
         r_safe_1 <= RED;
         r_safe_2 <= RED;
         r_fault  <= 1'b0;
         r_code   <= '0;
         r_chan   <= '0;
      end else if (r_state != S_FAULT && w_hit) begin
         r_state  <= S_FAULT;
         r_safe_1 <= RED;
         r_safe_2 <= RED;
         r_fault  <= 1'b1;
         r_code   <= w_code;
         r_chan   <= w_chan;
      end else begin
         unique case (r_state)
            S_INIT: begin
               r_state <= S_RUN;
               r_prev  <= r_cur;
               r_cnt   <= '0;
            end
            S_RUN: begin
               r_safe_1 <= r_cur[0];
               r_safe_2 <= r_cur[1];
               r_prev   <= r_cur;
               for (int i = 0; i < 2; i++) begin
                  if (w_chg[i])
                     r_cnt[i] <= CNT_ONE;
                  else if (r_cnt[i] != CNT_MAX)
                     r_cnt[i] <= r_cnt[i] + CNT_ONE;
               end
            end
            S_FAULT: begin
               if (clr_fault) begin
                  r_state <= S_INIT;
                  r_fault <= 1'b0;
                  r_code  <= '0;
                  r_chan  <= '0;
               end
            end
            default: r_state <= S_INIT;
         endcase
      end
   end

`ifdef TLMON_FAULT_CNT_EN
   logic [7:0] r_fcnt;

   // Counts FAULT entries, saturating; only reset clears it.
   always_ff @(posedge clk) begin
      if (!reset)
         r_fcnt <= '0;
      else if (r_state != S_FAULT && w_hit && r_fcnt != 8'hFF)
         r_fcnt <= r_fcnt + 8'd1;
   end

   assign fault_count = r_fcnt;
`endif

   assign safe_1     = r_safe_1;
   assign safe_2     = r_safe_2;
   assign fault      = r_fault;
   assign fault_code = r_code;
   assign fault_chan = r_chan;

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Safety stage directly downstream of traffic_lights. Consumes light_1/light_2 and drives the lamp outputs safe_1/safe_2.
- Passes legal light patterns through with one cycle of latency.
- Detects conflicts, bad encodings, illegal sequences and dwell-time violations. On any fault, latches a sticky fault report and forces both lamps to red.

Parameters:
- MIN_YELLOW, 3, minimum legal yellow dwell in clock cycles.
- MAX_GREEN, 50, green dwell (cycles) at which the green-timeout watchdog trips.
- CNT_W, 8, width of the per-channel dwell counters. Counters saturate at 2^CNT_W-1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- light_1  input  3  channel-1 light from traffic_lights; bit2=red, bit1=yellow, bit0=green; one-hot
- light_2  input  3  channel-2 light, same encoding
- clr_fault  input  1  single-cycle pulse; clears a latched fault
- safe_1  output  3  channel-1 lamp drive
- safe_2  output  3  channel-2 lamp drive
- fault  output  1  sticky fault flag
- fault_code  output  3  cause of the first fault: 0 none, 1 conflict, 2 invalid encoding, 3 illegal transition, 4 yellow too short, 5 green timeout
- fault_chan  output  2  channel of the fault: bit0=ch1, bit1=ch2; 2'b11 for conflict or simultaneous faults

Behaviour:
- Reset (reset==0 at posedge clk):
  - Outputs: fault=0, fault_code=0, fault_chan=0, safe_1=safe_2=3'b100.
  - Dwell counters cleared, prev-light registers cleared, FSM in INIT.
- Input stage: light_1/light_2 registered each cycle. All checks operate on the registered sample (cur) against the previous sample (prev).
- FSM states:
  - INIT: one cycle. Captures prev=cur, clears counters, performs no transition or dwell checks. The conflict and encoding checks are active. Next state is RUN, or FAULT if either active check fires.
  - RUN: all checks active. safe_n=cur_n. Goes to FAULT on any check firing.
  - FAULT: safe_1=safe_2=3'b100. fault, fault_code and fault_chan are held. Counters are frozen. clr_fault=1 moves to INIT, and outputs return to 0 on the next edge.
- Checks, evaluated in the same cycle:
  - conflict (1): both channels have a non-red bit set.
  - invalid (2): cur is not one-hot.
  - illegal transition (3): cur!=prev and the pair is not G->Y, Y->R or R->G.
  - yellow short (4): Y->R transition with the yellow dwell count < MIN_YELLOW.
  - green timeout (5): channel green and its dwell count == MAX_GREEN-1.
- Priority: when several codes fire in one cycle, the lowest code number wins. fault_chan ORs in every channel that fired that winning code.
- Fault detection timing:
  - fault, fault_code and the forced red on safe_n all appear at the same posedge, one cycle after the offending light sample.
  - The offending pattern never reaches safe_n.
- Dwell counter per channel:
  - Reset to 1 when cur!=prev, otherwise increments.
  - Saturates at all-ones; the saturated value counts as ≥ any threshold.
- Faults are sticky. A later or different fault does not overwrite fault_code.
- clr_fault outside FAULT is ignored.
- If the condition still exists after a clear: INIT relearns it. Conflict or invalid re-faults at the end of INIT; other checks re-fault in RUN.
- Reset asserted mid-operation (any state) overrides clr_fault and returns everything to reset values on that edge.

Optional Feature:
- Macro: TLMON_FAULT_CNT_EN.
- Defined:
  - Adds output port fault_count [7:0].
  - Increments by 1 on each entry into FAULT and saturates at 255.
  - Cleared only by reset; clr_fault does not clear it.
- Undefined: port and counter absent. All other behaviour is identical.

Test Plan:
- Legal cycle: after reset release, drive ch1 G(50 cy is too long, so use 10)->Y(3)->R and ch2 R throughout -> safe_n mirrors the inputs delayed 1 cycle, fault stays 0.
- Conflict: ch1=3'b001, ch2=3'b010 for one cycle -> next edge fault=1, fault_code=1, fault_chan=2'b11, safe_1=safe_2=3'b100.
- Encoding and sequence:
  - ch1=3'b011 -> fault_code=2, fault_chan=2'b01.
  - After reset, ch1 G->R directly -> fault_code=3.
- Dwell: ch2 yellow for 2 cycles then red -> fault_code=4, fault_chan=2'b10. Separately, ch1 green held 50 cycles -> fault_code=5 after 50 green samples.
- Clear and re-fault:
  - Pulse clr_fault with lights legal (both red) -> INIT then RUN, fault=0.
  - Pulse clr_fault with the conflict held -> fault=1 again after INIT.
  - With TLMON_FAULT_CNT_EN defined, fault_count=2.
- Reset mid-fault: drop reset while in FAULT with clr_fault=1 -> next edge all outputs at reset values, safe_n=3'b100.
